rbs_pipe_clk: RTL

//  Pipelined ripple-borrow subtractor with valid/ready handshake; counterpart to the registered ripple-carry adder.

---
 rtl/rbs_pkg.sv | 20 ++
 rtl/rbs_stage.sv | 38 +++
 rtl/rbs_pipe_clk.sv | 107 ++++++++++
 3 files changed

// File: rtl/rbs_pkg.sv
// Shared constants and stage payload type for the pipelined ripple-borrow subtractor.
package rbs_pkg;

  localparam int unsigned RBS_WIDTH = 32;
  localparam int unsigned RBS_SLICE = 8;

  // Payload carried between stages: operands ride along until their chunk is consumed.
  typedef struct packed {
    logic                 valid;
    logic [RBS_WIDTH-1:0] a;
    logic [RBS_WIDTH-1:0] b;
    logic [RBS_WIDTH-1:0] d_partial;
    logic                 borrow;
  } rbs_stage_t;

  function automatic int unsigned rbs_stages(input int unsigned width, input int unsigned slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/rbs_stage.sv
// One SLICE-bit ripple-borrow slice followed by its stage register with hold enable.
module rbs_stage
  import rbs_pkg::*;
#(
  parameter int unsigned SLICE   = RBS_SLICE,
  parameter int unsigned IDX     = 0,
  parameter type         stage_t = rbs_stage_t
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   en,
  input  stage_t in_p,
  output stage_t nxt_c,
  output stage_t q
);

  localparam int unsigned LO = IDX * SLICE;

  logic [SLICE:0] diff_c;

  // Resolve chunk IDX; the extra MSB of the difference is the borrow out of this slice.
  always_comb begin
    diff_c = {1'b0, in_p.a[LO +: SLICE]} - {1'b0, in_p.b[LO +: SLICE]}
           - (SLICE + 1)'(in_p.borrow);
    nxt_c                        = in_p;
    nxt_c.d_partial[LO +: SLICE] = diff_c[SLICE-1:0];
    nxt_c.borrow                 = diff_c[SLICE];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= nxt_c;
    end
  end

endmodule

// File: rtl/rbs_pipe_clk.sv
// Pipelined ripple-borrow subtractor {bo,d} = a - b - bi with valid/ready handshake.
// Define RBS_OVF_EN to add the registered signed-overflow output ovf.
module rbs_pipe_clk
  import rbs_pkg::*;
#(
  parameter int unsigned WIDTH = RBS_WIDTH,
  parameter int unsigned SLICE = RBS_SLICE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef RBS_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned STAGES = rbs_stages(WIDTH, SLICE);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d_partial;
    logic             borrow;
  } stage_t;

  stage_t pipe_in;
  stage_t stage_q   [STAGES];
  stage_t stage_nxt [STAGES];
  logic   stall;
  logic   adv;

  // Whole pipe freezes while the output is held; no bubble collapsing.
  assign stall   = stage_q[STAGES-1].valid & ~o_ready;
  assign adv     = ~stall;
  assign i_ready = ~stall;

  always_comb begin
    pipe_in           = '0;
    pipe_in.valid     = i_valid;
    pipe_in.a         = a;
    pipe_in.b         = b;
    pipe_in.borrow    = bi;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic unused_nxt;
    assign unused_nxt = ^stage_nxt[s];

    if (s == 0) begin : g_first
      rbs_stage #(
        .SLICE   (SLICE),
        .IDX     (s),
        .stage_t (stage_t)
      ) u_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (adv),
        .in_p    (pipe_in),
        .nxt_c   (stage_nxt[s]),
        .q       (stage_q[s])
      );
    end else begin : g_rest
      rbs_stage #(
        .SLICE   (SLICE),
        .IDX     (s),
        .stage_t (stage_t)
      ) u_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (adv),
        .in_p    (stage_q[s-1]),
        .nxt_c   (stage_nxt[s]),
        .q       (stage_q[s])
      );
    end
  end

  assign o_valid = stage_q[STAGES-1].valid;
  assign d       = stage_q[STAGES-1].d_partial;
  assign bo      = stage_q[STAGES-1].borrow;

  logic unused_last;
  assign unused_last = ^{stage_q[STAGES-1].a, stage_q[STAGES-1].b};

`ifdef RBS_OVF_EN
  // Overflow flop loads alongside the last stage so it always matches d.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
    end else if (adv) begin
      ovf <= (stage_nxt[STAGES-1].a[WIDTH-1] != stage_nxt[STAGES-1].b[WIDTH-1]) &
             (stage_nxt[STAGES-1].d_partial[WIDTH-1] != stage_nxt[STAGES-1].a[WIDTH-1]);
    end
  end
`endif

endmodule
